// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the divider self-test monitors.
package div_pkg;
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} meter_state_t;
    localparam int DEF_WIDTH = 16;
    function automatic logic [63:0] sat_value(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer followed by a rising-edge detector.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic sig_in,
    output logic s,
    output logic rise
);
    logic [SYNC_STAGES-1:0] ff;
    logic s_d;
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ff  <= '0;
            s_d <= 1'b0;
        end else begin
            ff  <= {ff[SYNC_STAGES-2:0], sig_in};
            s_d <= s;
        end
    end
    assign s    = ff[SYNC_STAGES-1];
    assign rise = s & ~s_d;
endmodule

// File: rtl/div_ratio_meter.sv
// div_ratio_meter: measures period and high time of a divided clock in clock cycles.
module div_ratio_meter
    import div_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             sig_in,
    output logic             busy,
    output logic             valid,
    output logic             overflow,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time
);
    localparam logic [WIDTH-1:0] SAT = WIDTH'(sat_value(WIDTH));
    meter_state_t state;
    logic [WIDTH-1:0] cnt, hcnt, hnext;
    logic s, rise, sat_hit;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .rst_n (rst_n),
        .sig_in(sig_in),
        .s     (s),
        .rise  (rise)
    );

    // hnext includes the current cycle so the window spans exactly one period
    assign hnext   = (hcnt == SAT) ? SAT : hcnt + WIDTH'(s);
    assign sat_hit = (cnt == SAT);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
            period    <= '0;
            high_time <= '0;
            cnt       <= '0;
            hcnt      <= '0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        hcnt  <= '0;
                    end
                    ARM: if (rise) begin
                        state <= MEASURE;
                        cnt   <= '0;
                        hcnt  <= '0;
                    end else if (sat_hit) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        valid     <= 1'b1;
                        overflow  <= 1'b1;
                        period    <= SAT;
                        high_time <= hcnt;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                    MEASURE: if (rise || sat_hit) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        valid     <= 1'b1;
                        overflow  <= ~rise;
                        period    <= sat_hit ? SAT : cnt + WIDTH'(1);
                        high_time <= hnext;
                    end else begin
                        cnt  <= cnt + WIDTH'(1);
                        hcnt <= hnext;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_ratio_meter.sv
// tb_div_ratio_meter: scoreboard bench for div_ratio_meter at WIDTH=4.
module tb_div_ratio_meter;
    typedef struct {
        logic [3:0] p;
        logic [3:0] h;
        logic       o;
    } exp_t;

    logic clock = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, sig_in = 1'b0;
    logic busy, valid, overflow;
    logic [3:0] period, high_time;
    exp_t q[$];
    int checks = 0, errors = 0;
    int per_len = 0, hi_len = 0, phase = 0;
    logic [3:0] last_period = 4'd0;

    div_ratio_meter #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .en       (en),
        .start    (start),
        .sig_in   (sig_in),
        .busy     (busy),
        .valid    (valid),
        .overflow (overflow),
        .period   (period),
        .high_time(high_time)
    );

    always #5 clock = ~clock;

    // divided-signal generator: high for hi_len of every per_len cycles, low when per_len is 0
    initial forever begin
        @(posedge clock);
        #1;
        if (per_len == 0) begin
            phase  = 0;
            sig_in = 1'b0;
        end else begin
            phase  = (phase + 1 >= per_len) ? 0 : phase + 1;
            sig_in = (phase < hi_len);
        end
    end

    initial forever begin
        @(negedge clock);
        if (valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid period=%0d high_time=%0d overflow=%0b", period, high_time, overflow);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (period !== e.p) begin
                    errors++;
                    $display("FAIL period got=%0d exp=%0d", period, e.p);
                end
                if (high_time !== e.h) begin
                    errors++;
                    $display("FAIL high_time got=%0d exp=%0d", high_time, e.h);
                end
                if (overflow !== e.o) begin
                    errors++;
                    $display("FAIL overflow got=%0b exp=%0b", overflow, e.o);
                end
                checks += 3;
                last_period = e.p;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic start_aligned();
        int target, n;
        target = (per_len > 5) ? per_len - 5 : 0;
        n = 0;
        while (phase != target && n < 100) begin
            @(posedge clock);
            #2;
            n++;
        end
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d exp=0", name, q.size());
            q.delete();
        end
        repeat (30) @(posedge clock);
    endtask

    task automatic test_reset();
        #1;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        if (period !== 4'd0) begin errors++; $display("FAIL reset_period got=%0d exp=0", period); end
        if (high_time !== 4'd0) begin errors++; $display("FAIL reset_high_time got=%0d exp=0", high_time); end
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        en = 1'b1;
    endtask

    task automatic test_div4();
        per_len = 4;
        hi_len  = 2;
        repeat (8) @(posedge clock);
        q.push_back('{p: 4'd4, h: 4'd2, o: 1'b0});
        @(posedge clock);
        #1 start = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_before_sample got=%0b exp=0", busy); end
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got=%0b exp=1", busy); end
        wait_empty(60, "div4");
    endtask

    task automatic test_div5_busy();
        per_len = 5;
        hi_len  = 2;
        repeat (8) @(posedge clock);
        q.push_back('{p: 4'd5, h: 4'd2, o: 1'b0});
        pulse_start();
        repeat (2) @(posedge clock);
        pulse_start();
        wait_empty(60, "div5");
    endtask

    task automatic test_arm_overflow();
        per_len = 0;
        repeat (8) @(posedge clock);
        q.push_back('{p: 4'd15, h: 4'd0, o: 1'b1});
        pulse_start();
        wait_empty(40, "arm_overflow");
    endtask

    task automatic test_measure_overflow();
        per_len = 20;
        hi_len  = 2;
        repeat (25) @(posedge clock);
        q.push_back('{p: 4'd15, h: 4'd1, o: 1'b1});
        start_aligned();
        wait_empty(60, "measure_overflow");
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_hold got=%0b exp=1", overflow); end
        per_len = 4;
        hi_len  = 2;
        repeat (8) @(posedge clock);
        q.push_back('{p: 4'd4, h: 4'd2, o: 1'b0});
        pulse_start();
        wait_empty(60, "recover_div4");
    endtask

    task automatic test_en_abort();
        logic [3:0] keep;
        keep = last_period;
        per_len = 12;
        hi_len  = 6;
        repeat (15) @(posedge clock);
        start_aligned();
        repeat (10) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_measure got=%0b exp=1", busy); end
        en = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL en_abort_busy got=%0b exp=0", busy); end
        if (period !== keep) begin errors++; $display("FAIL en_abort_period got=%0d exp=%0d", period, keep); end
        repeat (30) @(posedge clock);
        #1 en = 1'b1;
    endtask

    task automatic test_async_reset();
        start_aligned();
        repeat (10) @(posedge clock);
        @(negedge clock);
        #3 rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%0b exp=0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL async_overflow got=%0b exp=0", overflow); end
        if (period !== 4'd0) begin errors++; $display("FAIL async_period got=%0d exp=0", period); end
        if (high_time !== 4'd0) begin errors++; $display("FAIL async_high_time got=%0d exp=0", high_time); end
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
        per_len = 4;
        hi_len  = 2;
        repeat (8) @(posedge clock);
        q.push_back('{p: 4'd4, h: 4'd2, o: 1'b0});
        pulse_start();
        wait_empty(60, "post_reset_div4");
    endtask

    initial begin
        test_reset();
        test_div4();
        test_div5_busy();
        test_arm_overflow();
        test_measure_overflow();
        test_en_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
